// File: rtl/alu_pkg.sv
// Shared datapath types and elaboration helpers for the pipelined CLA adder.
package alu_pkg;

  typedef struct packed {
    logic cout;
    logic ovf;
    logic zero;
  } alu_flags_t;

  function automatic int unsigned calc_stages(input int unsigned width,
                                              input int unsigned stage_bits);
    return (stage_bits == 0) ? 1 : width / stage_bits;
  endfunction

  function automatic bit cfg_ok(input int unsigned width, input int unsigned stage_bits);
    return (stage_bits != 0) && (stage_bits % 4 == 0) &&
           (width != 0) && (width % stage_bits == 0);
  endfunction

  // Bit offset of stage <stage>'s remaining-b field in the packed b pipeline vector
  function automatic int unsigned b_offset(input int unsigned width,
                                           input int unsigned stage_bits,
                                           input int unsigned stage);
    int unsigned off;
    off = 0;
    for (int unsigned i = 0; i < stage; i++) off += width - i * stage_bits;
    return off;
  endfunction

endpackage

// File: rtl/cla_group_n.sv
// Combinational N-bit carry-lookahead adder: 4-bit P/G groups plus second-level lookahead.
module cla_group_n #(
  parameter int unsigned N = 8
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         c_in,
  output logic [N-1:0] sum,
  output logic         c_out,
  output logic         c_msb_in
);

  localparam int unsigned NG = N / 4;

  logic [N-1:0]  p;
  logic [N-1:0]  g;
  logic [N-1:0]  c;
  logic [NG-1:0] gp;
  logic [NG-1:0] gg;
  logic [NG:0]   gc;
  logic          term;

  assign p = a ^ b;
  assign g = a & b;

  always_comb begin
    gp   = '0;
    gg   = '0;
    gc   = '0;
    c    = '0;
    term = 1'b0;
    for (int k = 0; k < int'(NG); k++) begin
      gp[k] = &p[4*k +: 4];
      gg[k] = g[4*k+3] | (p[4*k+3] & g[4*k+2]) | (p[4*k+3] & p[4*k+2] & g[4*k+1]) |
              (&p[4*k+1 +: 3] & g[4*k]);
    end
    // Group carries as flat sum-of-products, no ripple between groups
    for (int j = 0; j <= int'(NG); j++) begin
      term = c_in;
      for (int k = 0; k < j; k++) term = term & gp[k];
      gc[j] = term;
      for (int i = 0; i < j; i++) begin
        term = gg[i];
        for (int k = i + 1; k < j; k++) term = term & gp[k];
        gc[j] = gc[j] | term;
      end
    end
    for (int k = 0; k < int'(NG); k++) begin
      c[4*k]   = gc[k];
      c[4*k+1] = g[4*k] | (p[4*k] & gc[k]);
      c[4*k+2] = g[4*k+1] | (p[4*k+1] & g[4*k]) | (p[4*k+1] & p[4*k] & gc[k]);
      c[4*k+3] = g[4*k+2] | (p[4*k+2] & g[4*k+1]) | (p[4*k+2] & p[4*k+1] & g[4*k]) |
                 (p[4*k+2] & p[4*k+1] & p[4*k] & gc[k]);
    end
  end

  assign sum      = p ^ c;
  assign c_out    = gc[NG];
  assign c_msb_in = c[N-1];

endmodule

// File: rtl/cla_pipe_adder.sv
// Pipelined carry-lookahead adder/subtractor, one STAGE_BITS slice per stage, global-advance handshake.
module cla_pipe_adder
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH      = 16,
  parameter int unsigned STAGE_BITS = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  localparam int unsigned SB     = STAGE_BITS;
  localparam int unsigned STAGES = calc_stages(WIDTH, STAGE_BITS);
  localparam int unsigned B_BITS = b_offset(WIDTH, SB, STAGES);

  if (!cfg_ok(WIDTH, STAGE_BITS)) begin : g_cfg_err
    $error("cla_pipe_adder: WIDTH must be a multiple of STAGE_BITS, STAGE_BITS a multiple of 4");
  end

  // Stage j register: acc holds finished sum slices below j*SB and untouched a slices above
  logic [STAGES-1:0] v_q, v_d;
  logic [STAGES-1:0] c_q, c_d;
  logic [STAGES-1:0] z_q, z_d;
  logic [WIDTH-1:0]  acc_q [STAGES];
  logic [WIDTH-1:0]  acc_d [STAGES];
  logic [B_BITS-1:0] b_q, b_d;

  logic              out_valid_q, out_valid_d;
  logic [WIDTH-1:0]  sum_q, sum_d;
  alu_flags_t        flags_q, flags_d;

  logic [SB-1:0]     s_sl [STAGES];
  logic [STAGES-1:0] co_sl;
  logic [STAGES-1:0] cm_sl;
  logic              adv_c;
  logic              unused_cmsb;

  assign adv_c       = ~out_valid_q | out_ready;
  assign in_ready    = adv_c;
  assign unused_cmsb = ^cm_sl;

  for (genvar j = 0; j < int'(STAGES); j++) begin : g_stage
    cla_group_n #(.N(SB)) u_cla (
      .a        (acc_q[j][j*SB +: SB]),
      .b        (b_q[b_offset(WIDTH, SB, j) +: SB]),
      .c_in     (c_q[j]),
      .sum      (s_sl[j]),
      .c_out    (co_sl[j]),
      .c_msb_in (cm_sl[j])
    );
  end

  always_comb begin
    v_d         = '0;
    c_d         = '0;
    z_d         = '0;
    b_d         = '0;
    for (int unsigned i = 0; i < STAGES; i++) acc_d[i] = '0;
    out_valid_d = 1'b0;
    sum_d       = '0;
    flags_d     = '0;

    v_d[0]           = in_valid;
    acc_d[0]         = a;
    b_d[WIDTH-1:0]   = sub ? ~b : b;
    c_d[0]           = sub ? ~cin : cin;
    z_d[0]           = 1'b1;

    for (int unsigned j = 0; j + 1 < STAGES; j++) begin
      v_d[j+1]               = v_q[j];
      acc_d[j+1]             = acc_q[j];
      acc_d[j+1][j*SB +: SB] = s_sl[j];
      c_d[j+1]               = co_sl[j];
      z_d[j+1]               = z_q[j] & (s_sl[j] == '0);
      for (int unsigned i = 0; i < WIDTH; i++) begin
        if (i < WIDTH - (j + 1) * SB)
          b_d[b_offset(WIDTH, SB, j + 1) + i] = b_q[b_offset(WIDTH, SB, j) + SB + i];
      end
    end

    // Final slice feeds the registered result and flags directly
    out_valid_d                     = v_q[STAGES-1];
    sum_d                           = acc_q[STAGES-1];
    sum_d[(STAGES-1)*SB +: SB]      = s_sl[STAGES-1];
    flags_d.cout                    = co_sl[STAGES-1];
    flags_d.ovf                     = cm_sl[STAGES-1] ^ co_sl[STAGES-1];
    flags_d.zero                    = z_q[STAGES-1] & (s_sl[STAGES-1] == '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v_q         <= '0;
      c_q         <= '0;
      z_q         <= '0;
      b_q         <= '0;
      for (int unsigned i = 0; i < STAGES; i++) acc_q[i] <= '0;
      out_valid_q <= 1'b0;
      sum_q       <= '0;
      flags_q     <= '0;
    end else if (adv_c) begin
      v_q         <= v_d;
      c_q         <= c_d;
      z_q         <= z_d;
      b_q         <= b_d;
      for (int unsigned i = 0; i < STAGES; i++) acc_q[i] <= acc_d[i];
      out_valid_q <= out_valid_d;
      sum_q       <= sum_d;
      flags_q     <= flags_d;
    end
  end

  assign out_valid = out_valid_q;
  assign sum       = sum_q;
  assign cout      = flags_q.cout;
  assign ovf       = flags_q.ovf;
  assign zero      = flags_q.zero;

endmodule

// File: tb/tb_cla_pipe_adder.sv
// Directed bench for cla_pipe_adder: flags, latency, backpressure, reset flush and width sweep.
module tb_cla_pipe_adder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct packed {
    logic [63:0] s;
    logic        cout;
    logic        ovf;
    logic        zero;
  } res_t;

  // Main 16/8 instance
  logic        rst, in_valid, in_ready, cin, sub, out_valid, out_ready, cout, ovf, zero;
  logic [15:0] a, b, sum;

  cla_pipe_adder #(.WIDTH(16), .STAGE_BITS(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
    .cin(cin), .sub(sub), .out_valid(out_valid), .out_ready(out_ready), .sum(sum),
    .cout(cout), .ovf(ovf), .zero(zero)
  );

  // Sweep instances share one stimulus bus, always ready downstream
  logic        sw_in_valid, sw_cin, sw_sub;
  logic [63:0] sw_a, sw_b;
  logic [3:0]  sw_rdy, sw_ov, sw_co, sw_of, sw_zr;
  logic [15:0] s1;
  logic [31:0] s2, s3;
  logic [63:0] s4;

  cla_pipe_adder #(.WIDTH(16), .STAGE_BITS(4)) dut_16x4 (
    .clk(clk), .rst(rst), .in_valid(sw_in_valid), .in_ready(sw_rdy[0]), .a(sw_a[15:0]),
    .b(sw_b[15:0]), .cin(sw_cin), .sub(sw_sub), .out_valid(sw_ov[0]), .out_ready(1'b1),
    .sum(s1), .cout(sw_co[0]), .ovf(sw_of[0]), .zero(sw_zr[0])
  );
  cla_pipe_adder #(.WIDTH(32), .STAGE_BITS(8)) dut_32x8 (
    .clk(clk), .rst(rst), .in_valid(sw_in_valid), .in_ready(sw_rdy[1]), .a(sw_a[31:0]),
    .b(sw_b[31:0]), .cin(sw_cin), .sub(sw_sub), .out_valid(sw_ov[1]), .out_ready(1'b1),
    .sum(s2), .cout(sw_co[1]), .ovf(sw_of[1]), .zero(sw_zr[1])
  );
  cla_pipe_adder #(.WIDTH(32), .STAGE_BITS(32)) dut_32x32 (
    .clk(clk), .rst(rst), .in_valid(sw_in_valid), .in_ready(sw_rdy[2]), .a(sw_a[31:0]),
    .b(sw_b[31:0]), .cin(sw_cin), .sub(sw_sub), .out_valid(sw_ov[2]), .out_ready(1'b1),
    .sum(s3), .cout(sw_co[2]), .ovf(sw_of[2]), .zero(sw_zr[2])
  );
  cla_pipe_adder #(.WIDTH(64), .STAGE_BITS(16)) dut_64x16 (
    .clk(clk), .rst(rst), .in_valid(sw_in_valid), .in_ready(sw_rdy[3]), .a(sw_a),
    .b(sw_b), .cin(sw_cin), .sub(sw_sub), .out_valid(sw_ov[3]), .out_ready(1'b1),
    .sum(s4), .cout(sw_co[3]), .ovf(sw_of[3]), .zero(sw_zr[3])
  );

  // Plain-arithmetic reference; overflow from operand/result signs
  function automatic res_t model(input int w, input logic [63:0] ma, input logic [63:0] mb,
                                 input logic msub, input logic mcin);
    logic [64:0] mask, full;
    logic [63:0] bb;
    logic        c0;
    res_t        r;
    mask   = (65'd1 << w) - 65'd1;
    bb     = msub ? ~mb : mb;
    c0     = msub ? ~mcin : mcin;
    full   = ({1'b0, ma} & mask) + ({1'b0, bb} & mask) + {64'd0, c0};
    r.s    = full[63:0] & mask[63:0];
    r.cout = full[w];
    r.ovf  = (ma[w-1] == bb[w-1]) && (r.s[w-1] != ma[w-1]);
    r.zero = (r.s == 64'd0);
    return r;
  endfunction

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic run_op(input string tag, input logic [15:0] ta, input logic [15:0] tb_,
                        input logic tsub, input logic tcin, input logic [15:0] es,
                        input logic ec, input logic eo, input logic ez);
    @(negedge clk);
    check_eq({tag, "/in_ready"}, in_ready, 1);
    a = ta; b = tb_; sub = tsub; cin = tcin; in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; a = 16'hDEAD; b = 16'hBEEF; sub = 1'b0; cin = 1'b1;
    check_eq({tag, "/valid_t0"}, out_valid, 0);
    @(negedge clk);
    check_eq({tag, "/valid_t1"}, out_valid, 0);
    @(negedge clk);
    check_eq({tag, "/valid_t2"}, out_valid, 1);
    check_eq({tag, "/sum"}, sum, es);
    check_eq({tag, "/cout"}, cout, ec);
    check_eq({tag, "/ovf"}, ovf, eo);
    check_eq({tag, "/zero"}, zero, ez);
  endtask

  task automatic sw_check(input string tag, input int stg, input int k, input logic ov,
                          input logic [63:0] s, input logic c, input logic o, input logic z,
                          input res_t e);
    check_eq({tag, "/valid"}, ov, (k == stg));
    if (k == stg) begin
      check_eq({tag, "/sum"}, s, e.s);
      check_eq({tag, "/cout"}, c, e.cout);
      check_eq({tag, "/ovf"}, o, e.ovf);
      check_eq({tag, "/zero"}, z, e.zero);
    end
  endtask

  task automatic sweep_op(input string tag, input logic [63:0] ta, input logic [63:0] tb_,
                          input logic tsub, input logic tcin);
    res_t e1, e2, e3, e4;
    e1 = model(16, ta, tb_, tsub, tcin);
    e2 = model(32, ta, tb_, tsub, tcin);
    e3 = model(32, ta, tb_, tsub, tcin);
    e4 = model(64, ta, tb_, tsub, tcin);
    @(negedge clk);
    sw_a = ta; sw_b = tb_; sw_sub = tsub; sw_cin = tcin; sw_in_valid = 1'b1;
    @(negedge clk);
    sw_in_valid = 1'b0;
    for (int k = 0; k <= 5; k++) begin
      sw_check({tag, "/16x4"},  4, k, sw_ov[0], {48'd0, s1}, sw_co[0], sw_of[0], sw_zr[0], e1);
      sw_check({tag, "/32x8"},  4, k, sw_ov[1], {32'd0, s2}, sw_co[1], sw_of[1], sw_zr[1], e2);
      sw_check({tag, "/32x32"}, 1, k, sw_ov[2], {32'd0, s3}, sw_co[2], sw_of[2], sw_zr[2], e3);
      sw_check({tag, "/64x16"}, 4, k, sw_ov[3], s4,          sw_co[3], sw_of[3], sw_zr[3], e4);
      @(negedge clk);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [15:0] sa [8];
    logic [15:0] sb [8];
    logic        ssub [8];
    logic        scin [8];
    res_t        exp_q [$];
    res_t        e;
    int          sent, got;
    logic        stall, exp_rdy, held_valid;
    logic [15:0] held_sum;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0;
    sw_in_valid = 1'b0; sw_a = '0; sw_b = '0; sw_cin = 1'b0; sw_sub = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("reset/out_valid", out_valid, 0);
    check_eq("reset/in_ready", in_ready, 1);
    check_eq("reset/sum", sum, 0);
    check_eq("reset/flags", {cout, ovf, zero}, 0);
    rst = 1'b0;

    run_op("add_00ff_1",   16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0, 1'b0);
    run_op("add_7fff_1",   16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0);
    run_op("add_ffff_1",   16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1);
    run_op("add_cin",      16'h1234, 16'h4321, 1'b0, 1'b1, 16'h5556, 1'b0, 1'b0, 1'b0);
    run_op("sub_5_7",      16'h0005, 16'h0007, 1'b1, 1'b0, 16'hFFFE, 1'b0, 1'b0, 1'b0);
    run_op("sub_8000_1",   16'h8000, 16'h0001, 1'b1, 1'b0, 16'h7FFF, 1'b1, 1'b1, 1'b0);
    run_op("sub_borrowin", 16'h1234, 16'h1233, 1'b1, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1);
    run_op("sub_0_0",      16'h0000, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1);

    // Back-to-back stream with a 3-cycle consumer stall
    for (int i = 0; i < 8; i++) begin
      sa[i] = 16'($urandom); sb[i] = 16'($urandom);
      ssub[i] = 1'($urandom); scin[i] = 1'($urandom);
    end
    sent = 0; got = 0; held_valid = 1'b0; held_sum = '0;
    for (int cyc = 0; cyc < 60 && got < 8; cyc++) begin
      @(negedge clk);
      stall = (cyc >= 4 && cyc < 7);
      if (held_valid) begin
        check_eq("stream/hold_valid", out_valid, 1);
        check_eq("stream/hold_sum", sum, held_sum);
      end
      out_ready = !stall;
      in_valid  = (sent < 8);
      if (sent < 8) begin
        a = sa[sent]; b = sb[sent]; sub = ssub[sent]; cin = scin[sent];
      end
      #1;
      exp_rdy = !out_valid || !stall;
      check_eq("stream/in_ready", in_ready, exp_rdy);
      if (out_valid && !stall) begin
        check_eq("stream/nonempty", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check_eq("stream/sum", sum, e.s);
          check_eq("stream/flags", {cout, ovf, zero}, {e.cout, e.ovf, e.zero});
        end
        got++;
      end
      held_valid = out_valid && stall;
      held_sum   = sum;
      if (in_valid && exp_rdy) begin
        exp_q.push_back(model(16, {48'd0, a}, {48'd0, b}, sub, cin));
        sent++;
      end
    end
    in_valid = 1'b0; out_ready = 1'b1;
    check_eq("stream/count", got, 8);
    check_eq("stream/leftover", exp_q.size(), 0);
    repeat (4) @(negedge clk);

    // Reset with two ops in flight; op offered during reset must be dropped
    a = 16'h1111; b = 16'h2222; sub = 1'b0; cin = 1'b0; in_valid = 1'b1;
    @(negedge clk);
    a = 16'h3333;
    @(negedge clk);
    check_eq("flush/pre_valid", out_valid, 0);
    rst = 1'b1; a = 16'h4444;
    @(negedge clk);
    rst = 1'b0; in_valid = 1'b0;
    check_eq("flush/out_valid", out_valid, 0);
    check_eq("flush/in_ready", in_ready, 1);
    check_eq("flush/sum", sum, 0);
    check_eq("flush/flags", {cout, ovf, zero}, 0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check_eq("flush/no_emit", out_valid, 0);
    end
    run_op("post_flush", 16'hA5A5, 16'h0F0F, 1'b0, 1'b0, 16'hB4B4, 1'b0, 1'b0, 1'b0);

    sweep_op("sw_ones_p1",  64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0);
    sweep_op("sw_ones_cin", 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b0, 1'b1);
    sweep_op("sw_alt_add",  64'h5555_5555_5555_5555, 64'hAAAA_AAAA_AAAA_AAAA, 1'b0, 1'b0);
    sweep_op("sw_alt_cin",  64'h5555_5555_5555_5555, 64'hAAAA_AAAA_AAAA_AAAA, 1'b0, 1'b1);
    sweep_op("sw_alt_sub",  64'hAAAA_AAAA_AAAA_AAAA, 64'h5555_5555_5555_5555, 1'b1, 1'b0);
    sweep_op("sw_0_m1",     64'h0, 64'h1, 1'b1, 1'b0);
    sweep_op("sw_ovf",      64'h7FFF_FFFF_7FFF_7FFF, 64'h1, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cla_pipe_adder.md
# cla_pipe_adder

Parametrised, pipelined carry-lookahead adder/subtractor for the processor datapath. It replaces fixed-width ripple-of-groups adders when wider operands or higher clock rates are needed. The operand is split into STAGE_BITS-wide slices, one slice per pipeline stage, with 4-bit lookahead groups inside each slice. Results carry full ALU flags and move through a valid/ready handshake with backpressure.

## Interface
- WIDTH, 16: operand/result width; must be a multiple of STAGE_BITS.
- STAGE_BITS, 8: bits resolved per pipeline stage; must be a multiple of 4.
- STAGES (derived, not overridable): WIDTH/STAGE_BITS, which is also the latency in cycles.
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operands present.
- in_ready  output  1  stage 0 can accept this cycle.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- cin  input  1  carry-in (add) or borrow-in (sub).
- sub  input  1  0: a+b+cin; 1: a−b−cin.
- out_valid  output  1  result present.
- out_ready  input  1  consumer accepts result.
- sum  output  WIDTH  result, modulo 2^WIDTH.
- cout  output  1  carry-out; in sub mode 1 = no borrow.
- ovf  output  1  two's-complement overflow.
- zero  output  1  sum == 0.

## Operation
- Effective operands: b_eff = sub ? ~b : b; c0 = sub ? ~cin : cin.
- Stage k (0..STAGES−1) adds slice [k*STAGE_BITS +: STAGE_BITS] of a and b_eff with the incoming carry. It uses 4-bit group propagate/generate and lookahead across the groups in the slice. There is no ripple across the full slice.
- Each stage register holds: valid bit; completed low sum slices; remaining unprocessed a/b_eff slices; carry into next slice; carry into the current MSB position; running zero-AND.
- Flags are computed from the final stage:
  - cout = carry out of bit WIDTH−1.
  - ovf = carry into bit WIDTH−1 XOR cout.
  - zero = AND over all slices of (slice == 0).
- Global-advance pipeline:
  - advance = !out_valid | out_ready; in_ready = advance.
  - On advance, every stage shifts one step. Stage 0 loads in_valid & in_ready.
  - On no advance, all stages hold, including sum/flags.
  - Bubbles (valid=0) propagate normally. Invalid stages' data contents are don't-care.
- Reset: all valid bits clear, so out_valid=0 and in_ready=1 the cycle after rst. sum, cout, ovf and zero reset to 0. Reset mid-operation discards all in-flight operations; no output is produced for them.
- rst has priority over the handshake: inputs offered in a cycle with rst=1 are not accepted.

## Timing
- Latency: operands accepted at rising edge T appear with out_valid=1 after edge T+STAGES−1+1, i.e. STAGES edges after acceptance.
- With STAGES=1, the result is registered one cycle after acceptance.
- Throughput: one result per cycle while out_ready=1.
- Result is held stable (sum/flags unchanged, out_valid=1) while out_valid & !out_ready.
- Simultaneous out_ready and in_valid with a full pipeline: the pipeline shifts, so pop and push occur in the same cycle with no bubble.
- in_ready is combinational from out_valid and out_ready. No combinational path exists from a, b, cin or sub to any output.
- Critical path: one slice of STAGE_BITS bits (group lookahead) plus a flag merge.

## Structure
- Shared package alu_pkg holds:
  - Localparam function for STAGES.
  - Flag struct typedef {cout, ovf, zero}.
  - Elaboration-time assertion helpers for the WIDTH and STAGE_BITS divisibility rules.
- One sub-module: cla_group_n. It is a combinational lookahead adder of parameter N (multiple of 4), built from 4-bit propagate/generate groups with a second-level lookahead. Inputs are a, b and c_in; outputs are sum, c_out and c_msb_in (carry into MSB). It is instantiated once per stage.
- The top level holds the stage registers, handshake logic and flag logic only.

## Test plan
- WIDTH=16, STAGE_BITS=8: add 0x00FF + 0x0001, cin=0 → sum=0x0100, cout=0, ovf=0, zero=0, out_valid exactly 2 cycles after acceptance.
- Add 0x7FFF + 0x0001 → 0x8000, ovf=1, cout=0. Add 0xFFFF + 0x0001 → 0x0000, cout=1, zero=1, ovf=0.
- Sub: 0x0005 − 0x0007, cin=0 → 0xFFFE, cout=0. Sub 0x8000 − 0x0001 → 0x7FFF, ovf=1, cout=1. Sub 0x1234 − 0x1233 with cin=1 → 0x0000, zero=1.
- Stream 8 back-to-back random ops; hold out_ready=0 for 3 cycles mid-stream → results in order, no loss or duplication, in_ready=0 while stalled with a full pipeline, sum stable while held. Compare against a reference model.
- Assert rst for 1 cycle with 2 ops in flight → next cycle out_valid=0 and in_ready=1, neither op is emitted, and a following op completes normally.
- Sweep configurations (WIDTH, STAGE_BITS) = (16,4), (32,8), (32,32), (64,16) with exhaustive carry-chain patterns (all-ones + 1, alternating 0x5…/0xA…) → correct sum and flags, with latency = STAGES.
